decode_stage: RTL and testbench

Parametrised, registered successor to the single-cycle decoder. It accepts a raw RV32I instruction plus PC over a valid/ready handshake and decodes it into immediate, ALU control, branch/memory/writeback controls and register indices. Results are held in one output pipeline register between fetch and execute. It adds width parametrisation, backpressure, flush, x0-write suppression and illegal-instruction detection.

---
 rtl/decode_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage.
// Decodes one instruction per cycle into execute controls and holds the
// result in a single output register that uses a valid/ready handshake.
// The immediate is sign-extended to XLEN. The register-index width is
// configurable. Writes to x0 are suppressed. Undecodable instructions are
// flagged so that execute can trap.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [XLEN-1:0]   imm,
  output logic [3:0]        alu_ctl,
  output logic              branch_uc,
  output logic              branch_c,
  output logic              mem_read,
  output logic              mem_write,
  output logic              alu_src,
  output logic              reg_write,
  output logic [REG_AW-1:0] read_reg1,
  output logic [REG_AW-1:0] read_reg2,
  output logic [REG_AW-1:0] write_reg,
  output logic              illegal
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_GE = 4'd8, ALU_LT = 4'd9, ALU_CHOOSEB = 4'd10, ALU_EQ = 4'd11,
    ALU_NE = 4'd12, ALU_GEU = 4'd13, ALU_LTU = 4'd14
  } alu_op_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_raw;
  logic [4:0] rs2_raw;
  logic [4:0] rd_raw;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign rs1_raw = in_instr[19:15];
  assign rs2_raw = in_instr[24:20];
  assign rd_raw  = in_instr[11:7];

  logic [31:0]       imm32_d;
  logic [3:0]        alu_ctl_d;
  logic              branch_uc_d;
  logic              branch_c_d;
  logic              mem_read_d;
  logic              mem_write_d;
  logic              alu_src_d;
  logic              reg_write_d;
  logic              illegal_d;
  logic              use_rs1;
  logic              use_rs2;
  logic              use_rd;
  logic              reg_oob;
  logic [REG_AW-1:0] rd_d;

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign rd_d     = in_instr[7 +: REG_AW];

  // Decode the incoming instruction into controls, an immediate and an illegal flag
  always_comb begin
    imm32_d     = 32'd0;
    alu_ctl_d   = ALU_AND;
    branch_uc_d = 1'b0;
    branch_c_d  = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    use_rd      = 1'b0;
    case (opcode)
      OP_OP: begin
        reg_write_d = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0: alu_ctl_d = ALU_ADD;
            3'd1: alu_ctl_d = ALU_SLL;
            3'd2: alu_ctl_d = ALU_LT;
            3'd3: alu_ctl_d = ALU_LTU;
            3'd4: alu_ctl_d = ALU_XOR;
            3'd5: alu_ctl_d = ALU_SRL;
            3'd6: alu_ctl_d = ALU_OR;
            default: alu_ctl_d = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          alu_ctl_d = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          alu_ctl_d = ALU_SRA;
        end else begin
          illegal_d = 1'b1;
        end
      end
      OP_IMM: begin
        alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm32_d = {{20{in_instr[31]}}, in_instr[31:20]};
        case (funct3)
          3'd0: alu_ctl_d = ALU_ADD;
          3'd1: begin
            alu_ctl_d = ALU_SLL;
            if (funct7 != 7'b0000000) illegal_d = 1'b1;
          end
          3'd2: alu_ctl_d = ALU_LT;
          3'd3: alu_ctl_d = ALU_LTU;
          3'd4: alu_ctl_d = ALU_XOR;
          3'd5: begin
            alu_ctl_d = in_instr[30] ? ALU_SRA : ALU_SRL;
            if ({funct7[6], funct7[4:0]} != 6'd0) illegal_d = 1'b1;
          end
          3'd6: alu_ctl_d = ALU_OR;
          default: alu_ctl_d = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        mem_read_d = 1'b1; alu_ctl_d = ALU_ADD; alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm32_d = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal_d = 1'b1;
      end
      OP_STORE: begin
        mem_write_d = 1'b1; alu_ctl_d = ALU_ADD; alu_src_d = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32_d = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        if (funct3 > 3'd2) illegal_d = 1'b1;
      end
      OP_BRANCH: begin
        branch_c_d = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        imm32_d = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
        case (funct3)
          3'd0: alu_ctl_d = ALU_EQ;
          3'd1: alu_ctl_d = ALU_NE;
          3'd4: alu_ctl_d = ALU_LT;
          3'd5: alu_ctl_d = ALU_GE;
          3'd6: alu_ctl_d = ALU_LTU;
          3'd7: alu_ctl_d = ALU_GEU;
          default: illegal_d = 1'b1;
        endcase
      end
      OP_JAL: begin
        branch_uc_d = 1'b1; alu_ctl_d = ALU_CHOOSEB; alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rd = 1'b1;
        imm32_d = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        branch_uc_d = 1'b1; alu_ctl_d = ALU_ADD; alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rs1 = 1'b1; use_rd = 1'b1;
        imm32_d = {{20{in_instr[31]}}, in_instr[31:20]};
        if (funct3 != 3'd0) illegal_d = 1'b1;
      end
      OP_LUI: begin
        alu_ctl_d = ALU_CHOOSEB; alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rd = 1'b1;
        imm32_d = {in_instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        alu_ctl_d = ALU_ADD; alu_src_d = 1'b1; reg_write_d = 1'b1;
        use_rd = 1'b1;
        imm32_d = {in_instr[31:12], 12'd0};
      end
      default: illegal_d = 1'b1;
    endcase

    // Register fields that name registers outside a narrowed register file make the instruction undecodable
    reg_oob = (use_rs1 && ((rs1_raw >> REG_AW) != 5'd0)) ||
              (use_rs2 && ((rs2_raw >> REG_AW) != 5'd0)) ||
              (use_rd  && ((rd_raw  >> REG_AW) != 5'd0));
    if (reg_oob) illegal_d = 1'b1;

    if (rd_d == '0) reg_write_d = 1'b0;

    if (illegal_d) begin
      alu_ctl_d   = ALU_AND;
      branch_uc_d = 1'b0;
      branch_c_d  = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      alu_src_d   = 1'b0;
      reg_write_d = 1'b0;
    end
  end

  // Output pipeline register: flush beats accept, accept beats drain, otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      imm       <= '0;
      alu_ctl   <= 4'd0;
      branch_uc <= 1'b0;
      branch_c  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      alu_src   <= 1'b0;
      reg_write <= 1'b0;
      read_reg1 <= '0;
      read_reg2 <= '0;
      write_reg <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      imm       <= XLEN'(signed'(imm32_d));
      alu_ctl   <= alu_ctl_d;
      branch_uc <= branch_uc_d;
      branch_c  <= branch_c_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      alu_src   <= alu_src_d;
      reg_write <= reg_write_d;
      read_reg1 <= in_instr[15 +: REG_AW];
      read_reg2 <= in_instr[20 +: REG_AW];
      write_reg <= rd_d;
      illegal   <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage.
// The main instance uses XLEN=64, and a second instance uses REG_AW=4.
module tb_decode_stage;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc;
  logic [63:0] a_imm;
  logic [3:0]  a_alu_ctl;
  logic        a_branch_uc, a_branch_c, a_mem_read, a_mem_write, a_alu_src, a_reg_write, a_illegal;
  logic [4:0]  a_rr1, a_rr2, a_wr;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc;
  logic [31:0] b_imm;
  logic [3:0]  b_alu_ctl;
  logic        b_branch_uc, b_branch_c, b_mem_read, b_mem_write, b_alu_src, b_reg_write, b_illegal;
  logic [3:0]  b_rr1, b_rr2, b_wr;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(64), .REG_AW(5), .PC_W(32)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .imm(a_imm), .alu_ctl(a_alu_ctl), .branch_uc(a_branch_uc), .branch_c(a_branch_c),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .alu_src(a_alu_src),
    .reg_write(a_reg_write), .read_reg1(a_rr1), .read_reg2(a_rr2),
    .write_reg(a_wr), .illegal(a_illegal)
  );

  decode_stage #(.XLEN(32), .REG_AW(4), .PC_W(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .imm(b_imm), .alu_ctl(b_alu_ctl), .branch_uc(b_branch_uc), .branch_c(b_branch_c),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .alu_src(b_alu_src),
    .reg_write(b_reg_write), .read_reg1(b_rr1), .read_reg2(b_rr2),
    .write_reg(b_wr), .illegal(b_illegal)
  );

  // Free-running clock with a 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy, input logic fl);
    a_in_valid  = valid;
    a_in_instr  = instr;
    a_in_pc     = pc;
    a_out_ready = rdy;
    a_flush     = fl;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    b_in_valid = 1'b0; b_in_instr = 32'd0; b_in_pc = 32'd0; b_out_ready = 1'b1; b_flush = 1'b0;
    #12;
    checkOutput("reset out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("reset in_ready", 64'(a_in_ready), 64'd1);
    checkOutput("reset imm", a_imm, 64'd0);
    checkOutput("reset reg_write", 64'(a_reg_write), 64'd0);
    rst = 1'b0;
    stepClk();

    // add x1,x2,x1
    applyStimulus(1'b1, 32'h001100B3, 32'h100, 1'b1, 1'b0);
    stepClk();
    checkOutput("add out_valid", 64'(a_out_valid), 64'd1);
    checkOutput("add alu_ctl", 64'(a_alu_ctl), 64'd2);
    checkOutput("add alu_src", 64'(a_alu_src), 64'd0);
    checkOutput("add reg_write", 64'(a_reg_write), 64'd1);
    checkOutput("add rs1", 64'(a_rr1), 64'd2);
    checkOutput("add rs2", 64'(a_rr2), 64'd1);
    checkOutput("add rd", 64'(a_wr), 64'd1);
    checkOutput("add illegal", 64'(a_illegal), 64'd0);
    checkOutput("add pc", 64'(a_out_pc), 64'h100);

    // addi x3,x5,-4 is issued back to back with the add.
    applyStimulus(1'b1, 32'hFFC28193, 32'h104, 1'b1, 1'b0);
    stepClk();
    checkOutput("addi imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("addi alu_src", 64'(a_alu_src), 64'd1);
    checkOutput("addi rd", 64'(a_wr), 64'd3);
    checkOutput("addi rs1", 64'(a_rr1), 64'd5);

    // bge x3,x4,-4
    applyStimulus(1'b1, 32'hFE41DEE3, 32'h108, 1'b1, 1'b0);
    stepClk();
    checkOutput("bge branch_c", 64'(a_branch_c), 64'd1);
    checkOutput("bge alu_ctl", 64'(a_alu_ctl), 64'd8);
    checkOutput("bge imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("bge reg_write", 64'(a_reg_write), 64'd0);

    // sra x5,x6,x7
    applyStimulus(1'b1, 32'h407352B3, 32'h10C, 1'b1, 1'b0);
    stepClk();
    checkOutput("sra alu_ctl", 64'(a_alu_ctl), 64'd7);
    checkOutput("sra rs2", 64'(a_rr2), 64'd7);

    // Drain: no new input, so out_valid drops and the data fields stay.
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    stepClk();
    checkOutput("drain out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("drain alu_ctl kept", 64'(a_alu_ctl), 64'd7);

    // Backpressure: lw is captured, then sw waits while execute stalls.
    applyStimulus(1'b1, 32'h0041A103, 32'h200, 1'b0, 1'b0);
    stepClk();
    applyStimulus(1'b1, 32'h00A0A423, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold in_ready", 64'(a_in_ready), 64'd0);
      checkOutput("hold out_valid", 64'(a_out_valid), 64'd1);
      checkOutput("hold lw mem_read", 64'(a_mem_read), 64'd1);
      checkOutput("hold lw imm", a_imm, 64'd4);
      checkOutput("hold lw rd", 64'(a_wr), 64'd2);
      checkOutput("hold lw pc", 64'(a_out_pc), 64'h200);
      stepClk();
    end
    applyStimulus(1'b1, 32'h00A0A423, 32'h204, 1'b1, 1'b0);
    #1;
    checkOutput("release in_ready", 64'(a_in_ready), 64'd1);
    stepClk();
    checkOutput("sw out_valid", 64'(a_out_valid), 64'd1);
    checkOutput("sw mem_write", 64'(a_mem_write), 64'd1);
    checkOutput("sw mem_read", 64'(a_mem_read), 64'd0);
    checkOutput("sw imm", a_imm, 64'd8);
    checkOutput("sw reg_write", 64'(a_reg_write), 64'd0);

    // A flush that coincides with jal drops the jal. A later jal is accepted.
    applyStimulus(1'b1, 32'h0100036F, 32'h300, 1'b1, 1'b1);
    stepClk();
    checkOutput("flush out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("flush branch_uc", 64'(a_branch_uc), 64'd0);
    applyStimulus(1'b1, 32'h0100036F, 32'h304, 1'b1, 1'b0);
    stepClk();
    checkOutput("jal out_valid", 64'(a_out_valid), 64'd1);
    checkOutput("jal branch_uc", 64'(a_branch_uc), 64'd1);
    checkOutput("jal alu_ctl", 64'(a_alu_ctl), 64'd10);
    checkOutput("jal imm", a_imm, 64'd16);
    checkOutput("jal rd", 64'(a_wr), 64'd6);

    // addi x0,x0,1 suppresses the write to x0.
    applyStimulus(1'b1, 32'h00100013, 32'h308, 1'b1, 1'b0);
    stepClk();
    checkOutput("x0 reg_write", 64'(a_reg_write), 64'd0);
    checkOutput("x0 illegal", 64'(a_illegal), 64'd0);

    // An unknown opcode is flagged, still arrives as valid and carries no controls.
    applyStimulus(1'b1, 32'h0000007F, 32'h30C, 1'b1, 1'b0);
    stepClk();
    checkOutput("illop illegal", 64'(a_illegal), 64'd1);
    checkOutput("illop out_valid", 64'(a_out_valid), 64'd1);
    checkOutput("illop controls",
                64'({a_branch_uc, a_branch_c, a_mem_read, a_mem_write, a_reg_write}), 64'd0);
    checkOutput("illop alu_ctl", 64'(a_alu_ctl), 64'd0);

    // sub with funct3=1 is an unsupported combination.
    applyStimulus(1'b1, 32'h402090B3, 32'h310, 1'b1, 1'b0);
    stepClk();
    checkOutput("badf7 illegal", 64'(a_illegal), 64'd1);
    checkOutput("badf7 reg_write", 64'(a_reg_write), 64'd0);

    // With REG_AW=4, add x16,x1,x1 names an out-of-range register, while add x1,x2,x1 is legal.
    b_in_valid = 1'b1; b_in_instr = 32'h00108833;
    stepClk();
    checkOutput("aw4 x16 illegal", 64'(b_illegal), 64'd1);
    checkOutput("aw4 x16 reg_write", 64'(b_reg_write), 64'd0);
    b_in_instr = 32'h001100B3;
    stepClk();
    checkOutput("aw4 add illegal", 64'(b_illegal), 64'd0);
    checkOutput("aw4 add rd", 64'(b_wr), 64'd1);
    b_in_valid = 1'b0;

    // Reset while an instruction is held clears out_valid between clock edges.
    applyStimulus(1'b1, 32'h001100B3, 32'h400, 1'b0, 1'b0);
    stepClk();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("prehold out_valid", 64'(a_out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", 64'(a_out_valid), 64'd0);
    checkOutput("async rst in_ready", 64'(a_in_ready), 64'd1);
    #1;
    rst = 1'b0;
    stepClk();
    checkOutput("post rst out_valid", 64'(a_out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
